// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage: datapath widths,
// load-type encodings, FSM states and the latched load descriptor.
package wb_stage_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LBU = 3'd1;
  localparam logic [2:0] LOAD_LH  = 3'd2;
  localparam logic [2:0] LOAD_LHU = 3'd3;
  localparam logic [2:0] LOAD_LW  = 3'd4;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic                      reg_write;
    logic [2:0]                ltype;
    logic [1:0]                offset;
  } load_req_t;

endpackage

// File: rtl/wb_stage_load_aligner.sv
// Combinational load data aligner: picks the addressed byte/half/word out of
// the raw memory word and extends it; flags misaligned or illegal loads.
module load_aligner
  import wb_stage_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input  logic [2:0]   type_i,
  input  logic [1:0]   offset_i,
  input  logic [W-1:0] word_i,
  output logic [W-1:0] value_o,
  output logic         misaligned_o
);

  logic [W-1:0] shifted;
  logic [7:0]   byte_v;
  logic [15:0]  half_v;

  // Halfwords only ever sit at offset 0 or 2, so the byte shift covers both.
  assign shifted = word_i >> {offset_i, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = shifted[15:0];

  always_comb begin
    value_o      = '0;
    misaligned_o = 1'b0;
    unique case (type_i)
      LOAD_LB:  value_o = {{(W-8){byte_v[7]}}, byte_v};
      LOAD_LBU: value_o = {{(W-8){1'b0}}, byte_v};
      LOAD_LH: begin
        value_o      = {{(W-16){half_v[15]}}, half_v};
        misaligned_o = offset_i[0];
      end
      LOAD_LHU: begin
        value_o      = {{(W-16){1'b0}}, half_v};
        misaligned_o = offset_i[0];
      end
      LOAD_LW: begin
        value_o      = word_i;
        misaligned_o = (offset_i != 2'd0);
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions, parks loads until the
// memory response arrives, and issues one registered register-file write each.
module wb_stage #(
  parameter int WORD_WIDTH     = wb_stage_pkg::WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = wb_stage_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic                      inRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] inWriteAddr,
  input  logic [WORD_WIDTH-1:0]     inAluValue,
  input  logic                      inIsLoad,
  input  logic [2:0]                inLoadType,
  input  logic [1:0]                inByteOffset,
  input  logic                      memRespValid,
  input  logic [WORD_WIDTH-1:0]     memRespData,
  output logic                      writeEnable,
  output logic [REG_ADDR_WIDTH-1:0] writeAddr,
  output logic [WORD_WIDTH-1:0]     writeValue,
  output logic                      busyLoad,
  output logic [REG_ADDR_WIDTH-1:0] busyAddr,
  output logic                      alignErr
);
  import wb_stage_pkg::*;

  wb_state_e                 state_q, state_d;
  load_req_t                 load_q, load_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0]     wval_q, wval_d;
  logic                      busy_q, busy_d;
  logic [REG_ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic                      aerr_q, aerr_d;

  logic [WORD_WIDTH-1:0]     aligned;
  logic                      misaligned;

  load_aligner #(.W(WORD_WIDTH)) u_align (
    .type_i       (load_q.ltype),
    .offset_i     (load_q.offset),
    .word_i       (memRespData),
    .value_o      (aligned),
    .misaligned_o (misaligned)
  );

  assign inReady = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    busy_d  = busy_q;
    baddr_d = baddr_q;
    aerr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          if (inIsLoad) begin
            load_d  = '{addr: inWriteAddr, reg_write: inRegWrite,
                        ltype: inLoadType, offset: inByteOffset};
            busy_d  = 1'b1;
            baddr_d = inWriteAddr;
            state_d = WAIT_MEM;
          end else begin
            we_d    = inRegWrite && (inWriteAddr != REG_ZERO);
            waddr_d = inWriteAddr;
            wval_d  = inAluValue;
          end
        end
      end
      WAIT_MEM: begin
        if (memRespValid) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          // A faulting load leaves the write port's address/data untouched.
          if (misaligned) begin
            aerr_d = 1'b1;
          end else begin
            we_d    = load_q.reg_write && (load_q.addr != REG_ZERO);
            waddr_d = load_q.addr;
            wval_d  = aligned;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      load_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wval_q  <= '0;
      busy_q  <= 1'b0;
      baddr_q <= '0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wval_q  <= wval_d;
      busy_q  <= busy_d;
      baddr_q <= baddr_d;
      aerr_q  <= aerr_d;
    end
  end

  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeValue  = wval_q;
  assign busyLoad    = busy_q;
  assign busyAddr    = baddr_q;
  assign alignErr    = aerr_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases plus random instruction
// streams, checked against a byte-arithmetic model of load extension.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0, inReady;
  logic        inRegWrite = 1'b0;
  logic [4:0]  inWriteAddr = '0;
  logic [31:0] inAluValue = '0;
  logic        inIsLoad = 1'b0;
  logic [2:0]  inLoadType = '0;
  logic [1:0]  inByteOffset = '0;
  logic        memRespValid = 1'b0;
  logic [31:0] memRespData = '0;
  logic        writeEnable, busyLoad, alignErr;
  logic [4:0]  writeAddr, busyAddr;
  logic [31:0] writeValue;

  wb_stage dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .inRegWrite(inRegWrite), .inWriteAddr(inWriteAddr), .inAluValue(inAluValue),
    .inIsLoad(inIsLoad), .inLoadType(inLoadType), .inByteOffset(inByteOffset),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeValue(writeValue),
    .busyLoad(busyLoad), .busyAddr(busyAddr), .alignErr(alignErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Load descriptor captured by the bench at acceptance time.
  bit [4:0] ld_addr;
  bit       ld_rw;
  int       ld_t, ld_off;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {error, value}: byte/half picked by shifting the word by 8*offset.
  function automatic bit [32:0] ref_load(int t, int off, bit [31:0] d);
    bit [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (8 * off)) & 32'hFFFF;
    case (t)
      0: return {1'b0, (b >= 128) ? b + 32'hFFFFFF00 : b};
      1: return {1'b0, b};
      2: return (off % 2 != 0) ? {1'b1, 32'h0}
                               : {1'b0, (h >= 32768) ? h + 32'hFFFF0000 : h};
      3: return (off % 2 != 0) ? {1'b1, 32'h0} : {1'b0, h};
      4: return (off != 0) ? {1'b1, 32'h0} : {1'b0, d};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Monitor: every write or alignment-error pulse must match the next entry.
  exp_t e;
  bit   ok;
  always @(negedge clk) begin
    if (rst && (writeEnable === 1'b1 || alignErr === 1'b1)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: we=%b aerr=%b addr=%0d val=%h, expected no event",
                 writeEnable, alignErr, writeAddr, writeValue);
      end else begin
        e = sb.pop_front();
        if (e.err) ok = (alignErr === 1'b1) && (writeEnable === 1'b0);
        else ok = (writeEnable === 1'b1) && (alignErr === 1'b0) &&
                  (writeAddr === e.addr) && (writeValue === e.val);
        if (!ok) begin
          miscompares++;
          $display("FAIL write_event: we=%b aerr=%b addr=%0d val=%h, expected err=%0d addr=%0d val=%h",
                   writeEnable, alignErr, writeAddr, writeValue, e.err, e.addr, e.val);
        end
      end
    end
  end

  task automatic drive(bit ld, bit rw, bit [4:0] a, bit [31:0] alu, bit [2:0] lt, bit [1:0] off);
    inValid = 1'b1; inIsLoad = ld; inRegWrite = rw; inWriteAddr = a;
    inAluValue = alu; inLoadType = lt; inByteOffset = off;
  endtask

  // Returns at posedge+1 after the accepting edge.
  task automatic wait_accept();
    bit acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = inReady;
      @(posedge clk);
    end
    #1;
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: inReady stayed %b, expected 1 within 20 cycles", inReady);
    end else if (inIsLoad) begin
      ld_addr = inWriteAddr; ld_rw = inRegWrite;
      ld_t = int'(inLoadType); ld_off = int'(inByteOffset);
    end else if (inRegWrite && inWriteAddr != 0) begin
      sb.push_back('{1'b0, inWriteAddr, inAluValue});
    end
    inValid = 1'b0;
  endtask

  task automatic resp(int delay, bit [31:0] data);
    bit [32:0] r;
    check("busyLoad_wait", 32'(busyLoad), 32'd1);
    check("busyAddr_wait", 32'(busyAddr), 32'(ld_addr));
    repeat (delay) begin
      check("inReady_wait", 32'(inReady), 32'd0);
      @(posedge clk); #1;
      check("busyLoad_wait", 32'(busyLoad), 32'd1);
    end
    r = ref_load(ld_t, ld_off, data);
    if (r[32]) sb.push_back('{1'b1, 5'd0, 32'd0});
    else if (ld_rw && ld_addr != 0) sb.push_back('{1'b0, ld_addr, r[31:0]});
    memRespValid = 1'b1; memRespData = data;
    @(posedge clk); #1;
    memRespValid = 1'b0; memRespData = $urandom;
    check("inReady_after_resp", 32'(inReady), 32'd1);
    check("busyLoad_after_resp", 32'(busyLoad), 32'd0);
  endtask

  task automatic do_alu(bit rw, bit [4:0] a, bit [31:0] v);
    drive(1'b0, rw, a, v, 3'd0, 2'd0);
    wait_accept();
  endtask

  task automatic do_load(bit rw, bit [4:0] a, bit [2:0] lt, bit [1:0] off, int delay, bit [31:0] d);
    drive(1'b1, rw, a, $urandom, lt, off);
    wait_accept();
    resp(delay, d);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_writeEnable"}, 32'(writeEnable), 32'd0);
    check({tag, "_writeAddr"},   32'(writeAddr),   32'd0);
    check({tag, "_writeValue"},  writeValue,       32'd0);
    check({tag, "_busyLoad"},    32'(busyLoad),    32'd0);
    check({tag, "_busyAddr"},    32'(busyAddr),    32'd0);
    check({tag, "_alignErr"},    32'(alignErr),    32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    rst = 1'b1;
    #1 check("inReady_after_reset", 32'(inReady), 32'd1);

    // Directed cases
    do_alu(1'b1, 5'd5, 32'h12345678);
    do_load(1'b1, 5'd3, 3'd0, 2'd3, 4, 32'h80FFFFFF);
    do_load(1'b1, 5'd4, 3'd1, 2'd3, 4, 32'h80FFFFFF);
    do_load(1'b1, 5'd6, 3'd2, 2'd2, 1, 32'h7FFF0000);
    do_load(1'b1, 5'd6, 3'd2, 2'd1, 2, 32'h7FFF0000);
    do_alu(1'b1, 5'd0, 32'hDEADBEEF);
    do_load(1'b1, 5'd0, 3'd4, 2'd0, 0, 32'hCAFEF00D);
    do_load(1'b1, 5'd8, 3'd5, 2'd0, 0, 32'h11111111);

    // New instruction held on the input while a load is outstanding
    drive(1'b1, 1'b1, 5'd10, 32'h0, 3'd3, 2'd2);
    wait_accept();
    drive(1'b0, 1'b1, 5'd11, 32'hA5A5A5A5, 3'd0, 2'd0);
    resp(3, 32'h9876ABCD);
    wait_accept();
    do_alu(1'b1, 5'd12, 32'h00000042);

    // Reset in the middle of a pending load
    drive(1'b1, 1'b1, 5'd9, 32'h0, 3'd4, 2'd0);
    wait_accept();
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1 check_zero_outputs("midreset");
    @(posedge clk); #1 rst = 1'b1;
    memRespValid = 1'b1; memRespData = 32'h55555555;
    @(posedge clk); #1 memRespValid = 1'b0;
    check("inReady_post_reset", 32'(inReady), 32'd1);
    check("busyLoad_post_reset", 32'(busyLoad), 32'd0);
    repeat (2) @(posedge clk); #1;

    // Random mix, including back-to-back ALU ops and held instructions
    for (int n = 0; n < 300; n++) begin
      bit        rw;
      bit [4:0]  a;
      rw = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b1, rw, a, $urandom, 3'($urandom_range(0, 7)), 2'($urandom));
        wait_accept();
        if ($urandom_range(0, 1) == 1) begin
          drive(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 3'd0, 2'd0);
          resp($urandom_range(0, 3), $urandom);
          wait_accept();
        end else begin
          resp($urandom_range(0, 3), $urandom);
        end
      end else begin
        do_alu(rw, a, $urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the toy CPU pipeline, sitting directly upstream of the register file and driving its single write port. It accepts retiring instructions from the memory stage over a valid/ready handshake, holds loads until the data-memory response arrives, aligns and sign/zero-extends load data, and issues exactly one registered register-file write per retired instruction. It also exports a pending-load indication so decode can stall on a load-use hazard.

## Interface
Parameters:
- WORD_WIDTH, 32, datapath width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- inValid  in  1  memory stage presents a retiring instruction
- inReady  out  1  stage can accept; high only in IDLE
- inRegWrite  in  1  instruction writes a destination register
- inWriteAddr  in  REG_ADDR_WIDTH  destination register index
- inAluValue  in  WORD_WIDTH  result for non-load instructions
- inIsLoad  in  1  instruction is a load
- inLoadType  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; 5–7 illegal
- inByteOffset  in  2  address[1:0] of the load
- memRespValid  in  1  data-memory response strobe
- memRespData  in  WORD_WIDTH  raw aligned word from data memory
- writeEnable  out  1  register-file write strobe, one-cycle pulse
- writeAddr  out  REG_ADDR_WIDTH  register-file write index
- writeValue  out  WORD_WIDTH  register-file write data
- busyLoad  out  1  a load is outstanding
- busyAddr  out  REG_ADDR_WIDTH  destination of the outstanding load
- alignErr  out  1  one-cycle pulse: misaligned or illegal load, write suppressed

## Operation
- FSM states: IDLE, WAIT_MEM. Reset state IDLE.
- inReady = (state == IDLE), combinational.
- Accept = inValid && inReady.
- IDLE, accept, !inIsLoad: next cycle writeEnable = inRegWrite && inWriteAddr != 0, writeAddr = inWriteAddr, writeValue = inAluValue; stay IDLE.
- IDLE, accept, inIsLoad: latch addr, regWrite, type, offset; go WAIT_MEM.
- WAIT_MEM: busyLoad = 1, busyAddr = latched addr. memRespValid low: hold. memRespValid high: align, register write outputs, go IDLE.
- Alignment (lane k = memRespData[8k+7:8k]): LB/LBU take lane offset, sign-/zero-extend to 32. LH/LHU: offset 0 → [15:0], offset 2 → [31:16], extend; offset 1 or 3 → misaligned. LW: offset 0 → full word; nonzero offset → misaligned.
- Misaligned or illegal type: writeEnable stays 0, alignErr pulses with the cycle the write would have occurred; FSM still returns to IDLE.
- Writes to register 0 never assert writeEnable, whether from loads or ALU results.
- memRespValid in IDLE is ignored.
- Non-writing cycles: writeEnable = 0; writeAddr/writeValue hold their last values.

## Timing
- All outputs except inReady are registered.
- Reset values: writeEnable 0, writeAddr 0, writeValue 0, busyLoad 0, busyAddr 0, alignErr 0; inReady 1 once reset deasserts.
- Non-load latency: accept at edge N → writeEnable high for cycle N+1 only.
- Load latency: response sampled at edge M → write outputs valid in cycle M+1, inReady high in cycle M+1, busyLoad low in cycle M+1.
- Back-to-back non-loads: one accept per cycle, one write per cycle.
- A load response arriving in the same cycle as acceptance of that load is not possible, because the FSM is in IDLE. Responses are only consumed from the cycle after entry to WAIT_MEM.
- Write outputs change at posedge and are stable across the following negedge, where the register file samples them.
- Reset asserted mid-WAIT_MEM: immediate return to IDLE, all outputs at reset values, pending load discarded.

## Structure
- Shared package: WORD_WIDTH, REG_ADDR_WIDTH, REG_ZERO, load-type encodings LOAD_LB..LOAD_LW.
- Sub-module load_aligner (combinational): inputs type, offset, raw word; outputs aligned value and misaligned flag. wb_stage holds the FSM, latches and output registers.

## Test plan
- Non-load: inAluValue 0x12345678, addr 5, regWrite 1 → next cycle writeEnable 1, writeAddr 5, writeValue 0x12345678; following cycle writeEnable 0.
- LB, offset 3, response 0x80FFFFFF after 4 wait cycles → busyLoad 1 and busyAddr set during the wait, then writeValue 0xFFFFFF80; LBU with the same stimulus → 0x00000080.
- LH, offset 2, response 0x7FFF0000 → 0x00007FFF; LH offset 1 → alignErr pulse, no write, inReady back high.
- Write to register 0 via ALU and via LW → writeEnable never asserted.
- Load pending, inValid held high with a new instruction → inReady 0 until the cycle after memRespValid; the new instruction is accepted then; no lost or duplicated writes.
- Reset driven low during WAIT_MEM → outputs zero asynchronously; a later memRespValid produces no write.
